// File: rtl/shift_pkg.sv
// Shared types and constants for the shift issue stage.
//   sel encodings : SH_SRL / SH_SRA / SH_SLL / SH_NONE
//   funct3 values : F3_SLL, F3_SR
//   shift_payload_t : registered payload {A, B, sel, rd, illegal}
//   decode_shift  : funct3/funct7b5 -> {illegal, sel}
package shift_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [1:0] SH_SRL  = 2'b00;
  localparam logic [1:0] SH_SRA  = 2'b01;
  localparam logic [1:0] SH_SLL  = 2'b10;
  localparam logic [1:0] SH_NONE = 2'b11;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0]    A;
    logic [SHAMT_W-1:0] B;
    logic [1:0]         sel;
    logic [4:0]         rd;
    logic               illegal;
  } shift_payload_t;

  // Idle payload: the shift unit sees "no shift" with zero operands.
  localparam shift_payload_t PAYLOAD_RESET = '{
    A:       '0,
    B:       '0,
    sel:     SH_NONE,
    rd:      '0,
    illegal: 1'b0
  };

  // Returns {illegal, sel}.
  function automatic logic [2:0] decode_shift(logic [2:0] funct3, logic funct7b5);
    logic [2:0] res;
    res = {1'b1, SH_NONE};
    case (funct3)
      F3_SLL:  if (!funct7b5) res = {1'b0, SH_SLL};
      F3_SR:   res = funct7b5 ? {1'b0, SH_SRA} : {1'b0, SH_SRL};
      default: res = {1'b1, SH_NONE};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/shift_issue_stage_if.sv
// Bus bundle for the shift issue stage.
//   Upstream side : in_* payload, in_valid/in_ready handshake
//   Forwarding    : fwd_mem_*, fwd_wb_*
//   Control       : flush
//   Downstream    : out_* payload, out_valid/out_ready handshake
// modport slave is the stage itself; modport master is its environment.
interface shift_issue_stage_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
);

  logic               in_valid;
  logic               in_ready;
  logic [4:0]         in_rs1_addr;
  logic [4:0]         in_rs2_addr;
  logic [XLEN-1:0]    in_rs1_data;
  logic [XLEN-1:0]    in_rs2_data;
  logic [XLEN-1:0]    in_imm;
  logic               in_use_imm;
  logic [2:0]         in_funct3;
  logic               in_funct7b5;
  logic [4:0]         in_rd;

  logic               fwd_mem_en;
  logic [4:0]         fwd_mem_rd;
  logic [XLEN-1:0]    fwd_mem_data;
  logic               fwd_wb_en;
  logic [4:0]         fwd_wb_rd;
  logic [XLEN-1:0]    fwd_wb_data;

  logic               flush;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_A;
  logic [SHAMT_W-1:0] out_B;
  logic [1:0]         out_sel;
  logic [4:0]         out_rd;
  logic               out_illegal;

  modport slave (
    input  in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data, in_imm,
           in_use_imm, in_funct3, in_funct7b5, in_rd,
           fwd_mem_en, fwd_mem_rd, fwd_mem_data, fwd_wb_en, fwd_wb_rd, fwd_wb_data,
           flush, out_ready,
    output in_ready, out_valid, out_A, out_B, out_sel, out_rd, out_illegal
  );

  modport master (
    output in_valid, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data, in_imm,
           in_use_imm, in_funct3, in_funct7b5, in_rd,
           fwd_mem_en, fwd_mem_rd, fwd_mem_data, fwd_wb_en, fwd_wb_rd, fwd_wb_data,
           flush, out_ready,
    input  in_ready, out_valid, out_A, out_B, out_sel, out_rd, out_illegal
  );

endinterface

// File: rtl/shift_skid_buf.sv
// Generic two-entry valid/ready skid register.
//   clk, rst            : clock, async active-high reset
//   flush               : drop both entries on the next edge; blocks acceptance
//   in_valid/in_ready   : upstream handshake; in_ready is registered (skid empty)
//   in_data             : payload captured on accept
//   out_valid/out_ready : downstream handshake
//   out_data            : main-entry payload, held while stalled
module shift_skid_buf #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {StEmpty, StFull1, StFull2} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             load_main_in, load_main_skid, load_skid;
  logic             accept, emit;

  assign in_ready  = (state_q != StFull2);
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;

  assign accept = in_valid & in_ready & ~flush;
  assign emit   = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_d      = StFull1;
        end
      end
      StFull1: begin
        if (emit && accept) begin
          load_main_in = 1'b1;
        end else if (emit) begin
          state_d = StEmpty;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = StFull2;
        end
      end
      StFull2: begin
        if (emit) begin
          load_main_skid = 1'b1;
          state_d        = StFull1;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Downstream still sees an emit this cycle; only the held entries die.
    if (flush) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Issue stage in front of the shift unit: resolves MEM/WB forwarding for rs1/rs2,
// decodes funct3/funct7b5 into the shift select, and registers {A, B, sel, rd, illegal}
// behind a skid buffer (1-cycle latency, full throughput).
//   clk, rst : clock, async active-high reset
//   bus      : shift_issue_stage_if.slave (input payload, forwarding, flush, output payload)
// XLEN/SHAMT_W must match the widths in shift_pkg, which size the payload struct.
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  shift_issue_stage_if.slave  bus
);

  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic [2:0]      dec;
  shift_payload_t  in_pl, out_pl;

  // MEM beats WB; x0 is never forwarded.
  function automatic logic [XLEN-1:0] resolve(
    logic [4:0]      addr,
    logic [XLEN-1:0] rf_data,
    logic            mem_en,
    logic [4:0]      mem_rd,
    logic [XLEN-1:0] mem_data,
    logic            wb_en,
    logic [4:0]      wb_rd,
    logic [XLEN-1:0] wb_data
  );
    logic [XLEN-1:0] res;
    res = rf_data;
    if (addr != 5'd0) begin
      if (mem_en && (mem_rd == addr)) begin
        res = mem_data;
      end else if (wb_en && (wb_rd == addr)) begin
        res = wb_data;
      end
    end
    return res;
  endfunction

  always_comb begin
    rs1_fwd = resolve(bus.in_rs1_addr, bus.in_rs1_data, bus.fwd_mem_en, bus.fwd_mem_rd,
                      bus.fwd_mem_data, bus.fwd_wb_en, bus.fwd_wb_rd, bus.fwd_wb_data);
    rs2_fwd = resolve(bus.in_rs2_addr, bus.in_rs2_data, bus.fwd_mem_en, bus.fwd_mem_rd,
                      bus.fwd_mem_data, bus.fwd_wb_en, bus.fwd_wb_rd, bus.fwd_wb_data);
  end

  assign dec = decode_shift(bus.in_funct3, bus.in_funct7b5);

  always_comb begin
    in_pl         = PAYLOAD_RESET;
    in_pl.A       = rs1_fwd;
    in_pl.B       = bus.in_use_imm ? bus.in_imm[SHAMT_W-1:0] : rs2_fwd[SHAMT_W-1:0];
    in_pl.sel     = dec[1:0];
    in_pl.illegal = dec[2];
    in_pl.rd      = bus.in_rd;
  end

  // Shift amounts above the low SHAMT_W bits are architecturally ignored.
  logic unused_upper;
  assign unused_upper = ^{bus.in_imm[XLEN-1:SHAMT_W], rs2_fwd[XLEN-1:SHAMT_W]};

  shift_skid_buf #(
    .WIDTH     ($bits(shift_payload_t)),
    .RESET_VAL (PAYLOAD_RESET)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_pl),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_pl)
  );

  assign bus.out_A       = out_pl.A;
  assign bus.out_B       = out_pl.B;
  assign bus.out_sel     = out_pl.sel;
  assign bus.out_rd      = out_pl.rd;
  assign bus.out_illegal = out_pl.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage: a queue-based reference model checked every
// cycle, plus literal expectations on the hand-worked vectors.
module tb_shift_issue_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_issue_stage_if #(.XLEN(32), .SHAMT_W(5)) bus ();

  shift_issue_stage #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] a;
    logic [4:0]  b;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];

  function automatic logic [31:0] pick(input logic [4:0] addr, input logic [31:0] rf);
    if (addr == 5'd0) return rf;
    if (bus.fwd_mem_en && bus.fwd_mem_rd == addr) return bus.fwd_mem_data;
    if (bus.fwd_wb_en && bus.fwd_wb_rd == addr) return bus.fwd_wb_data;
    return rf;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    logic [31:0] amt;
    e.a   = pick(bus.in_rs1_addr, bus.in_rs1_data);
    amt   = bus.in_use_imm ? bus.in_imm : pick(bus.in_rs2_addr, bus.in_rs2_data);
    e.b   = 5'(amt % 32);
    e.rd  = bus.in_rd;
    e.ill = 1'b0;
    if (bus.in_funct3 == 3'd1 && !bus.in_funct7b5) e.sel = 2'd2;
    else if (bus.in_funct3 == 3'd5) e.sel = bus.in_funct7b5 ? 2'd1 : 2'd0;
    else begin
      e.sel = 2'd3;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      bit   acc, em;
      exp_t e;
      acc = bus.in_valid && (q.size() < 2) && !bus.flush;
      em  = (q.size() > 0) && bus.out_ready;
      e   = predict();
      if (em) void'(q.pop_front());
      if (bus.flush) q.delete();
      else if (acc) q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("m_in_ready", {31'b0, bus.in_ready}, (q.size() < 2) ? 32'd1 : 32'd0);
      chk("m_out_valid", {31'b0, bus.out_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
      if (q.size() != 0) begin
        chk("m_out_A", bus.out_A, q[0].a);
        chk("m_out_B", {27'b0, bus.out_B}, {27'b0, q[0].b});
        chk("m_out_sel", {30'b0, bus.out_sel}, {30'b0, q[0].sel});
        chk("m_out_rd", {27'b0, bus.out_rd}, {27'b0, q[0].rd});
        chk("m_out_illegal", {31'b0, bus.out_illegal}, {31'b0, q[0].ill});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic [4:0] r1a, input logic [31:0] r1d, input logic [4:0] r2a,
                        input logic [31:0] r2d, input logic [31:0] imm, input logic use_imm,
                        input logic [2:0] f3, input logic f7, input logic [4:0] rd);
    bus.in_valid    = 1'b1;
    bus.in_rs1_addr = r1a;
    bus.in_rs1_data = r1d;
    bus.in_rs2_addr = r2a;
    bus.in_rs2_data = r2d;
    bus.in_imm      = imm;
    bus.in_use_imm  = use_imm;
    bus.in_funct3   = f3;
    bus.in_funct7b5 = f7;
    bus.in_rd       = rd;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    chk({tag, "_out_A"}, bus.out_A, 32'd0);
    chk({tag, "_out_B"}, {27'b0, bus.out_B}, 32'd0);
    chk({tag, "_out_sel"}, {30'b0, bus.out_sel}, 32'd3);
    chk({tag, "_out_rd"}, {27'b0, bus.out_rd}, 32'd0);
    chk({tag, "_out_illegal"}, {31'b0, bus.out_illegal}, 32'd0);
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_rs1_addr  = '0;
    bus.in_rs2_addr  = '0;
    bus.in_rs1_data  = '0;
    bus.in_rs2_data  = '0;
    bus.in_imm       = '0;
    bus.in_use_imm   = 1'b0;
    bus.in_funct3    = '0;
    bus.in_funct7b5  = 1'b0;
    bus.in_rd        = '0;
    bus.fwd_mem_en   = 1'b0;
    bus.fwd_mem_rd   = '0;
    bus.fwd_mem_data = '0;
    bus.fwd_wb_en    = 1'b0;
    bus.fwd_wb_rd    = '0;
    bus.fwd_wb_data  = '0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b0;

    @(negedge clk);
    chk_reset("rst0");
    rst           = 1'b0;
    cmp_en        = 1'b1;
    bus.out_ready = 1'b1;

    // SRAI
    set_in(5'd1, 32'h8000_0000, 5'd2, 32'h0, 32'd4, 1'b1, 3'b101, 1'b1, 5'd7);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("srai_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("srai_A", bus.out_A, 32'h8000_0000);
    chk("srai_B", {27'b0, bus.out_B}, 32'd4);
    chk("srai_sel", {30'b0, bus.out_sel}, 32'd1);
    chk("srai_rd", {27'b0, bus.out_rd}, 32'd7);
    @(negedge clk);
    chk("srai_drain", {31'b0, bus.out_valid}, 32'd0);

    // Forwarding, streamed back to back
    bus.fwd_mem_en = 1'b1; bus.fwd_mem_rd = 5'd5; bus.fwd_mem_data = 32'h1234;
    bus.fwd_wb_en  = 1'b1; bus.fwd_wb_rd  = 5'd5; bus.fwd_wb_data  = 32'hFFFF;
    set_in(5'd5, 32'hDEAD_BEEF, 5'd6, 32'h0, 32'd3, 1'b1, 3'b001, 1'b0, 5'd1);
    @(negedge clk);
    chk("fwd_mem_A", bus.out_A, 32'h1234);
    bus.fwd_mem_en = 1'b0;
    @(negedge clk);
    chk("fwd_wb_A", bus.out_A, 32'hFFFF);
    bus.fwd_mem_en = 1'b1; bus.fwd_mem_rd = 5'd6; bus.fwd_mem_data = 32'h3;
    set_in(5'd5, 32'hDEAD_BEEF, 5'd6, 32'h1F, 32'd0, 1'b0, 3'b101, 1'b0, 5'd2);
    @(negedge clk);
    chk("fwd_rs2_B", {27'b0, bus.out_B}, 32'd3);
    chk("fwd_rs2_A", bus.out_A, 32'hFFFF);
    chk("srl_sel", {30'b0, bus.out_sel}, 32'd0);
    bus.fwd_mem_rd = 5'd0; bus.fwd_wb_rd = 5'd0;
    set_in(5'd0, 32'hCAFE_0001, 5'd0, 32'h11, 32'd9, 1'b1, 3'b001, 1'b0, 5'd2);
    @(negedge clk);
    chk("x0_nofwd_A", bus.out_A, 32'hCAFE_0001);
    chk("x0_imm_B", {27'b0, bus.out_B}, 32'd9);
    bus.fwd_mem_en = 1'b0; bus.fwd_wb_en = 1'b0;

    // Register-shamt truncation
    set_in(5'd1, 32'h0000_00F0, 5'd3, 32'h25, 32'h0, 1'b0, 3'b001, 1'b0, 5'd4);
    @(negedge clk);
    chk("trunc_B", {27'b0, bus.out_B}, 32'd5);
    chk("trunc_sel", {30'b0, bus.out_sel}, 32'd2);

    // Illegal encodings
    set_in(5'd1, 32'h1, 5'd3, 32'h1, 32'h1, 1'b1, 3'b001, 1'b1, 5'd4);
    @(negedge clk);
    chk("ill_sel", {30'b0, bus.out_sel}, 32'd3);
    chk("ill_flag", {31'b0, bus.out_illegal}, 32'd1);
    set_in(5'd1, 32'h1, 5'd3, 32'h1, 32'h1, 1'b1, 3'b000, 1'b0, 5'd4);
    @(negedge clk);
    chk("ill_f3_0", {31'b0, bus.out_illegal}, 32'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Backpressure with three back-to-back inputs
    bus.out_ready = 1'b0;
    set_in(5'd1, 32'h111, 5'd0, 32'h0, 32'd1, 1'b1, 3'b001, 1'b0, 5'd11);
    @(negedge clk);
    chk("bp1_in_ready", {31'b0, bus.in_ready}, 32'd1);
    set_in(5'd1, 32'h222, 5'd0, 32'h0, 32'd2, 1'b1, 3'b101, 1'b0, 5'd12);
    @(negedge clk);
    chk("bp2_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("bp2_A", bus.out_A, 32'h111);
    set_in(5'd1, 32'h333, 5'd0, 32'h0, 32'd3, 1'b1, 3'b101, 1'b1, 5'd13);
    @(negedge clk);
    chk("bp3_stall_A", bus.out_A, 32'h111);
    chk("bp3_in_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_emit2_A", bus.out_A, 32'h222);
    chk("bp_emit2_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    chk("bp_emit3_A", bus.out_A, 32'h333);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drain", {31'b0, bus.out_valid}, 32'd0);

    // Flush while FULL2 with an input offered
    bus.out_ready = 1'b0;
    set_in(5'd1, 32'h444, 5'd0, 32'h0, 32'd1, 1'b1, 3'b001, 1'b0, 5'd1);
    @(negedge clk);
    set_in(5'd1, 32'h555, 5'd0, 32'h0, 32'd1, 1'b1, 3'b001, 1'b0, 5'd2);
    @(negedge clk);
    chk("fl_full2", {31'b0, bus.in_ready}, 32'd0);
    set_in(5'd1, 32'h666, 5'd0, 32'h0, 32'd1, 1'b1, 3'b001, 1'b0, 5'd3);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("fl_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("fl_in_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("fl_dropped", {31'b0, bus.out_valid}, 32'd0);

    // Flush in FULL1 with emit and accept in the same cycle
    bus.out_ready = 1'b1;
    set_in(5'd1, 32'h777, 5'd0, 32'h0, 32'd1, 1'b1, 3'b001, 1'b0, 5'd4);
    @(negedge clk);
    set_in(5'd1, 32'h888, 5'd0, 32'h0, 32'd1, 1'b1, 3'b001, 1'b0, 5'd5);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("fl1_out_valid", {31'b0, bus.out_valid}, 32'd0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Async reset while FULL1
    bus.out_ready = 1'b0;
    set_in(5'd1, 32'h999, 5'd0, 32'h0, 32'd7, 1'b1, 3'b101, 1'b1, 5'd9);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("ar_full1", {31'b0, bus.out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ar_after", {31'b0, bus.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
